// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronization request front-end.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } fsync_port_state_e;

    typedef enum logic {
        RSP_STORED,
        RSP_MATCH
    } fsync_rsp_e;

    // Signature is {level, id}; callers truncate the result to their SIG_WIDTH.
    function automatic logic [31:0] fsync_pack_sig(input logic [31:0] level,
                                                   input logic [31:0] id,
                                                   input int unsigned id_width);
        return (level << id_width) | id;
    endfunction

endpackage

// File: rtl/fractal_sync_mp_port_fsm.sv
// One requester port: IDLE/CHECK/RESP sequencer with its request and response registers.
module fractal_sync_mp_port_fsm
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LVL_WIDTH = 2,
    parameter int unsigned ID_WIDTH  = 4,
    localparam int unsigned SIG_WIDTH = LVL_WIDTH + ID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [LVL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]  req_id_i,
    input  logic                 stall_i,
    output logic                 in_check_o,
    output logic                 cam_check_o,
    output logic                 cam_sig_valid_o,
    output logic [SIG_WIDTH-1:0] cam_sig_o,
    input  logic                 cam_present_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_match_o,
    output logic [LVL_WIDTH-1:0] rsp_level_o,
    output logic [ID_WIDTH-1:0]  rsp_id_o
);

    fsync_port_state_e    state_q;
    logic [LVL_WIDTH-1:0] req_level_p0;
    logic [ID_WIDTH-1:0]  req_id_p0;
    fsync_rsp_e           rsp_match_p1;
    logic [LVL_WIDTH-1:0] rsp_level_p1;
    logic [ID_WIDTH-1:0]  rsp_id_p1;
    logic                 req_hs;

    assign in_check_o      = (state_q == CHECK);
    assign cam_check_o     = in_check_o && !stall_i;
    assign cam_sig_valid_o = cam_check_o;
    assign req_ready_o     = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    assign req_hs          = req_valid_i && req_ready_o;
    assign cam_sig_o       = SIG_WIDTH'(fsync_pack_sig(32'(req_level_p0), 32'(req_id_p0), ID_WIDTH));
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_match_o     = (rsp_match_p1 == RSP_MATCH);
    assign rsp_level_o     = rsp_level_p1;
    assign rsp_id_o        = rsp_id_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_level_p0 <= '0;
            req_id_p0    <= '0;
            rsp_match_p1 <= RSP_STORED;
            rsp_level_p1 <= '0;
            rsp_id_p1    <= '0;
        end else begin
            // p0: request register, loaded on every accepted request
            if (req_hs) begin
                req_level_p0 <= req_level_i;
                req_id_p0    <= req_id_i;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid_i) state_q <= CHECK;
                end
                CHECK: begin
                    // p1: response register, loaded on the same edge the CAM updates its line
                    if (!stall_i) begin
                        state_q      <= RESP;
                        rsp_match_p1 <= cam_present_i ? RSP_MATCH : RSP_STORED;
                        rsp_level_p1 <= req_level_p0;
                        rsp_id_p1    <= req_id_p0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) state_q <= req_valid_i ? CHECK : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fractal_sync_mp_port_ctrl.sv
// Multi-port request front-end: per-port FSMs plus the same-signature collision stall network.
module fractal_sync_mp_port_ctrl
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned LVL_WIDTH = 2,
    parameter int unsigned ID_WIDTH  = 4,
    localparam int unsigned SIG_WIDTH = LVL_WIDTH + ID_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_PORTS-1:0]                  req_valid_i,
    output logic [N_PORTS-1:0]                  req_ready_o,
    input  logic [N_PORTS-1:0][LVL_WIDTH-1:0]   req_level_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]    req_id_i,
    output logic [N_PORTS-1:0]                  cam_check_o,
    output logic [N_PORTS-1:0][SIG_WIDTH-1:0]   cam_sig_o,
    output logic [N_PORTS-1:0]                  cam_sig_valid_o,
    input  logic [N_PORTS-1:0]                  cam_present_i,
    output logic [N_PORTS-1:0]                  rsp_valid_o,
    input  logic [N_PORTS-1:0]                  rsp_ready_i,
    output logic [N_PORTS-1:0]                  rsp_match_o,
    output logic [N_PORTS-1:0][LVL_WIDTH-1:0]   rsp_level_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]    rsp_id_o
);

    logic [N_PORTS-1:0] in_check;
    logic [N_PORTS-1:0] stall;

    // A port yields to any lower-index port that is checking the same signature this cycle;
    // the winner itself must be unstalled, so equal signatures drain one per cycle in port order.
    always_comb begin
        logic [N_PORTS-1:0] blk;
        blk = '0;
        for (int j = 1; j < N_PORTS; j++) begin
            for (int i = 0; i < j; i++) begin
                if (in_check[i] && !blk[i] && (cam_sig_o[i] == cam_sig_o[j])) blk[j] = 1'b1;
            end
        end
        stall = blk;
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        fractal_sync_mp_port_fsm #(
            .LVL_WIDTH (LVL_WIDTH),
            .ID_WIDTH  (ID_WIDTH)
        ) u_fsm (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .req_valid_i     (req_valid_i[g]),
            .req_ready_o     (req_ready_o[g]),
            .req_level_i     (req_level_i[g]),
            .req_id_i        (req_id_i[g]),
            .stall_i         (stall[g]),
            .in_check_o      (in_check[g]),
            .cam_check_o     (cam_check_o[g]),
            .cam_sig_valid_o (cam_sig_valid_o[g]),
            .cam_sig_o       (cam_sig_o[g]),
            .cam_present_i   (cam_present_i[g]),
            .rsp_valid_o     (rsp_valid_o[g]),
            .rsp_ready_i     (rsp_ready_i[g]),
            .rsp_match_o     (rsp_match_o[g]),
            .rsp_level_o     (rsp_level_o[g]),
            .rsp_id_o        (rsp_id_o[g])
        );
    end

endmodule

// File: doc/fractal_sync_mp_port_ctrl.md
# fractal_sync_mp_port_ctrl

Per-port request front-end for the multi-port fractal synchronization CAM. It accepts barrier requests (level, id) from N_PORTS requesters over valid/ready and forms signatures. It issues one CAM check per request and resolves same-cycle signature collisions between ports. It returns a per-port response (MATCH or STORED) to the downstream propagation/notification logic.

## Interface
- N_PORTS, default 2: number of requester ports; must equal the CAM's N_PORTS.
- LVL_WIDTH, default 2: width of the barrier level field.
- ID_WIDTH, default 4: width of the barrier id field.
- SIG_WIDTH, localparam = LVL_WIDTH+ID_WIDTH: signature width; signature is {level, id}.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i[N_PORTS]  in  1  request valid.
- req_ready_o[N_PORTS]  out  1  request accepted when valid & ready.
- req_level_i[N_PORTS]  in  LVL_WIDTH  request level.
- req_id_i[N_PORTS]  in  ID_WIDTH  request barrier id.
- cam_check_o[N_PORTS]  out  1  CAM check strobe.
- cam_sig_o[N_PORTS]  out  SIG_WIDTH  CAM signature.
- cam_sig_valid_o[N_PORTS]  out  1  CAM signature valid.
- cam_present_i[N_PORTS]  in  1  CAM present result; combinational from cam_sig_o.
- rsp_valid_o[N_PORTS]  out  1  response valid.
- rsp_ready_i[N_PORTS]  in  1  response consumed when valid & ready.
- rsp_match_o[N_PORTS]  out  1  1 = MATCH (partner already stored, line freed); 0 = STORED (first arrival).
- rsp_level_o[N_PORTS], rsp_id_o[N_PORTS]  out  LVL_WIDTH / ID_WIDTH  echo of the request.

## Operation
- Each port has an independent FSM with states IDLE, CHECK and RESP. Each port holds one request register and one response register.
- IDLE:
  - req_ready_o=1.
  - On handshake, latch level/id and go to CHECK.
- CHECK:
  - req_ready_o=0.
  - If not stalled: cam_sig_valid_o=1 and cam_check_o=1 for exactly this cycle.
  - Sample cam_present_i into rsp_match, copy level/id into the response register, and go to RESP.
  - If stalled: both strobes are 0 and the port stays in CHECK.
- Collision stall: port j is stalled when any port i<j is in CHECK, unstalled, with an equal signature. The lowest index wins.
  - Same-signature requests are therefore checked in ascending port order, one per cycle.
  - This prevents two lines from being written with the same signature.
- RESP:
  - rsp_valid_o=1; response fields are stable until the handshake.
  - On rsp_ready_i, go to IDLE. req_ready_o = rsp_ready_i in this state.
  - If req_valid_i is also high, latch the new request and go straight to CHECK (back-to-back).
- cam_sig_o always drives the request register, including when the strobes are low.
- The block never drives cam_sig_valid_o without cam_check_o.

## Timing
- Reset values: all FSMs IDLE; req_ready_o=1; cam_check_o=0; cam_sig_valid_o=0; rsp_valid_o=0; rsp_match_o=0; cam_sig_o=0; rsp_level_o/rsp_id_o=0.
- Latency:
  - Request handshake at edge k puts the port in CHECK during cycle k+1.
  - With no stall, rsp_valid_o is high from cycle k+2.
  - Each collision stall adds one cycle.
- Throughput: one request per 2 cycles per port when rsp_ready_i is held high.
- cam_present_i is used only in the unstalled CHECK cycle. The CAM updates its line on the same edge that loads the response register.
- Reset mid-operation: a pending request or response is discarded with no CAM strobe. The CAM shares rst_ni, so no stale lines remain.
- Ports are fully independent except for the collision stall. A stalled port never blocks lower-index ports.

## Structure
- fractal_sync_pkg gets:
  - fsync_port_state_e enum {IDLE, CHECK, RESP}.
  - fsync_rsp_e {RSP_STORED, RSP_MATCH}.
  - A helper function for signature packing ({level, id}).
- Sub-module fractal_sync_mp_port_fsm: one per port, holding the FSM plus the request and response registers.
- The top level instantiates N_PORTS copies and a combinational collision-stall network built from pairwise signature compares.

## Test plan
- Single port, level=1 id=3 with the CAM empty → one check pulse with cam_sig_o=0x13 and present=0, rsp_valid at k+2 with match=0. Repeating the same request → match=1.
- Ports 0 and 1 request level=2 id=5 in the same cycle → port 0 checks at k+1 (STORED), port 1 checks at k+2 (MATCH), rsp_match = {0,1}.
- Ports 0 and 1 request different signatures in the same cycle → both check at k+1 with no stall, both STORED.
- rsp_ready_i low for 5 cycles → response fields stable, req_ready_o=0, no further check pulses. Then ready high with a new request → back-to-back entry to CHECK.
- rst_ni asserted while a port is in CHECK or RESP → all outputs return to reset values immediately, no check pulse afterwards.
- Random multi-port traffic against the CAM model → every check is paired, and the MATCH count equals half the arrivals per signature.
